// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, the halt opcode and the fetch state encoding.
// ins_mem, ins_fetch and decode all size themselves from these values.
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int INSTR_W = 8;
    localparam logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: synchronous reset, redirect load, and increment
// that wraps modulo 2^ADDR_W.
module pc_counter #(
    parameter int ADDR_W = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Redirect load has priority over the fetch increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: owns the PC, reads ins_mem combinationally and presents
// one instruction at a time to decode over valid/ready, with redirect and HALT.
module ins_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              load;
    logic [ADDR_W-1:0] pc;

    pc_counter #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .load   (redirect_valid),
        .load_pc(redirect_pc),
        .inc    (load),
        .pc     (pc)
    );

    assign mem_addr = pc;
    assign halted   = (state == HALTED);

    // A load fills the output register whenever it is empty or being drained;
    // a redirect suppresses it so the stale sequential instruction is never captured.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (redirect_valid) begin
            state_nxt = FETCH;
        end else if (state == FETCH && (!instr_valid || instr_ready)) begin
            load = 1'b1;
            if (mem_instr == HALT_OPCODE) begin
                state_nxt = HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (redirect_valid) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            instr_valid <= 1'b1;
            instr       <= mem_instr;
            instr_pc    <= pc;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural fetch model.
module tb_ins_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] mem_addr;
    logic [7:0] mem_instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [3:0] instr_pc;
    logic       redirect_valid;
    logic [3:0] redirect_pc;
    logic       halted;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit model_ok = 0;
    int m_pc, m_ipc, m_instr;
    bit m_valid, m_halted;

    always #5 clk = ~clk;

    assign mem_instr = mem[mem_addr];

    ins_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_instr     (mem_instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string name, input int v, input int ipc, input int ins);
        chk({name, " valid"}, int'(instr_valid), v);
        if (v != 0) begin
            chk({name, " instr_pc"}, int'(instr_pc), ipc);
            chk({name, " instr"}, int'(instr), ins);
        end
    endtask

    // Model: what fetch must do at each clock edge, from the spec's rules.
    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_halted = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (redirect_valid) begin
                m_pc = int'(redirect_pc); m_valid = 0; m_halted = 0;
            end else if (!m_halted && (!m_valid || instr_ready)) begin
                m_instr = int'(mem[m_pc]);
                m_ipc = m_pc;
                m_valid = 1;
                if (m_instr == 255) m_halted = 1;
                m_pc = (m_pc + 1) % 16;
            end else if (m_valid && instr_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model mem_addr", int'(mem_addr), m_pc);
            chk("model valid", int'(instr_valid), int'(m_valid));
            chk("model halted", int'(halted), int'(m_halted));
            if (m_valid) begin
                chk("model instr_pc", int'(instr_pc), m_ipc);
                chk("model instr", int'(instr), m_instr);
            end
        end
    end

    initial begin
        int exp_run [8];
        exp_run = '{0, 2, 4, 16, 32, 64, 128, 255};
        mem = '{8'd0, 8'd2, 8'd4, 8'd16, 8'd32, 8'd64, 8'd128, 8'd255,
                8'd0, 8'd100, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0};
        rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();

        // Reset state
        chk("reset valid", int'(instr_valid), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset halted", int'(halted), 0);
        chk("reset instr", int'(instr), 0);
        chk("reset instr_pc", int'(instr_pc), 0);

        // Streaming from reset
        rst = 1'b0; instr_ready = 1'b1;
        tick(); exp_out("s1 first", 1, 0, 0);
        chk("s1 mem_addr", int'(mem_addr), 1);
        tick(); exp_out("s1 second", 1, 1, 2);
        tick(); exp_out("s1 third", 1, 2, 4);

        // Backpressure
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); exp_out("s2 hold", 1, 2, 4);
            chk("s2 hold mem_addr", int'(mem_addr), 3);
        end
        instr_ready = 1'b1;
        tick(); exp_out("s2 release", 1, 3, 16);
        tick(); exp_out("s4 pre", 1, 4, 32);

        // Redirect while outputting (4,32)
        redirect_valid = 1'b1; redirect_pc = 4'd9;
        tick(); exp_out("s4 bubble", 0, 0, 0);
        chk("s4 bubble mem_addr", int'(mem_addr), 9);
        redirect_valid = 1'b0;
        tick(); exp_out("s4 target", 1, 9, 100);
        tick(); exp_out("s4 next", 1, 10, 0);

        // Free run into HALT
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(); exp_out("s3 run", 1, k, exp_run[k]);
        end
        chk("s3 halted at halt", int'(halted), 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("s3 halted valid", int'(instr_valid), 0);
            chk("s3 halted mem_addr", int'(mem_addr), 8);
            chk("s3 halted flag", int'(halted), 1);
        end

        // Redirect out of HALTED
        redirect_valid = 1'b1; redirect_pc = 4'd9;
        tick(); exp_out("s4h bubble", 0, 0, 0);
        chk("s4h halted clear", int'(halted), 0);
        redirect_valid = 1'b0;
        tick(); exp_out("s4h target", 1, 9, 100);
        tick(); exp_out("s4h next", 1, 10, 0);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 4'd14;
        tick(); redirect_valid = 1'b0;
        tick(); exp_out("s5 14", 1, 14, 0);
        tick(); exp_out("s5 15", 1, 15, 0);
        tick(); exp_out("s5 wrap0", 1, 0, 0);
        tick(); exp_out("s5 wrap1", 1, 1, 2);

        // Reset during stall, then reset against redirect
        redirect_valid = 1'b1; redirect_pc = 4'd5;
        tick(); redirect_valid = 1'b0; instr_ready = 1'b0;
        tick(); exp_out("s6 loaded", 1, 5, 64);
        tick(); exp_out("s6 stalled", 1, 5, 64);
        chk("s6 stalled mem_addr", int'(mem_addr), 6);
        rst = 1'b1;
        tick(); exp_out("s6 reset", 0, 0, 0);
        chk("s6 reset mem_addr", int'(mem_addr), 0);
        redirect_valid = 1'b1; redirect_pc = 4'd9;
        tick();
        chk("s6 rst beats redirect", int'(mem_addr), 0);
        rst = 1'b0; redirect_valid = 1'b0;

        // Randomized traffic checked by the model every cycle
        for (int k = 0; k < 2000; k++) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 4'($urandom_range(0, 15));
            rst            = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0; redirect_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
